frame_sync: RTL and testbench

Frame-tick consumer that sits between the 30 fps frame tick generator and the downstream per-frame pipeline (decoder/display fetch). It samples the one-cycle `frame` pulse, turns each tick into a req/ack transaction toward the consumer, and measures the cycle interval between ticks. It also counts ticks that arrive while a request is still outstanding, and flags a lost tick source via a watchdog.

---
 rtl/frame_sync_pkg.sv | 20 ++
 rtl/frame_gap_counter.sv | 30 +++
 rtl/frame_sync.sv | 134 +++++++++++++
 tb/tb_frame_sync.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: shared types and constants for the frame tick consumer.
// Holds the FSM encoding, counter widths and frame timing constants.
package frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_READY = 2'd2,
        ST_REQ   = 2'd3
    } state_t;

    localparam int GAP_W  = 32;
    localparam int FNUM_W = 16;

    // Nominal 30 fps period of the tick generator, and the watchdog
    // default chosen to sit just above it.
    localparam logic [31:0] FRAME_PERIOD    = 32'd2424243;
    localparam logic [31:0] TIMEOUT_DEFAULT = 32'd2600000;

endpackage

// File: rtl/frame_gap_counter.sv
// frame_gap_counter: saturating cycle counter between frame ticks.
// Ports: clk, rst (sync, active-high), clear, run -> count, timeout.
module frame_gap_counter
    import frame_sync_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    output logic [GAP_W-1:0] count,
    output logic             timeout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + GAP_W'(1);
        end
    end

    // Compared against the pre-edge value, so the flag acts at the edge
    // TIMEOUT cycles after the tick that zeroed the counter.
    assign timeout = (count >= (TIMEOUT - 32'd1));

endmodule

// File: rtl/frame_sync.sv
// frame_sync: turns frame ticks into req/ack transactions, measures the
// tick interval, counts dropped ticks and flags a lost tick source.
// Ports: CLK, RST (sync, active-high), enable, frame, ack ->
//        req, interval, interval_valid, frame_num, drop_count, lost.
module frame_sync
    import frame_sync_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT,
    parameter int          DROP_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              frame,
    input  logic              ack,
    output logic              req,
    output logic [GAP_W-1:0]  interval,
    output logic              interval_valid,
    output logic [FNUM_W-1:0] frame_num,
    output logic [DROP_W-1:0] drop_count,
    output logic              lost
);

    state_t              state;
    state_t              state_n;
    logic                req_n;
    logic                iv_n;
    logic                lost_n;
    logic [GAP_W-1:0]    interval_n;
    logic [FNUM_W-1:0]   fnum_n;
    logic [DROP_W-1:0]   drop_n;
    logic [GAP_W-1:0]    gap;
    logic                gap_timeout;
    logic                tick;
    logic                gap_run;
    logic                gap_clear;

    assign gap_run   = (state != ST_OFF);
    assign tick      = frame && gap_run;
    assign gap_clear = !enable || !gap_run || tick;

    frame_gap_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_gap (
        .clk     (CLK),
        .rst     (RST),
        .clear   (gap_clear),
        .run     (gap_run),
        .count   (gap),
        .timeout (gap_timeout)
    );

    always_comb begin
        state_n    = state;
        iv_n       = 1'b0;
        lost_n     = lost;
        interval_n = interval;
        fnum_n     = frame_num;
        drop_n     = drop_count;

        if (!enable) begin
            state_n    = ST_OFF;
            lost_n     = 1'b0;
            interval_n = '0;
            fnum_n     = '0;
            drop_n     = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_n = ST_ARMED;
                end
                ST_ARMED: begin
                    if (frame) begin
                        state_n = ST_REQ;
                        fnum_n  = frame_num + FNUM_W'(1);
                    end
                end
                ST_READY, ST_REQ: begin
                    if (frame) begin
                        state_n = ST_REQ;
                        fnum_n  = frame_num + FNUM_W'(1);
                        // A tick landing together with ack completes the
                        // old request, so only an unacked one is a drop.
                        if ((state == ST_REQ) && !ack &&
                            (drop_count != '1)) begin
                            drop_n = drop_count + DROP_W'(1);
                        end
                        // The gap after a lost source is meaningless,
                        // so the recovering tick only clears the flag.
                        if (lost) begin
                            lost_n = 1'b0;
                        end else begin
                            interval_n = gap + GAP_W'(1);
                            iv_n       = 1'b1;
                        end
                    end else begin
                        if ((state == ST_REQ) && ack) begin
                            state_n = ST_READY;
                        end
                        if (gap_timeout) begin
                            lost_n = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = ST_OFF;
                end
            endcase
        end

        req_n = (state_n == ST_REQ);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_OFF;
            req            <= 1'b0;
            interval       <= '0;
            interval_valid <= 1'b0;
            frame_num      <= '0;
            drop_count     <= '0;
            lost           <= 1'b0;
        end else begin
            state          <= state_n;
            req            <= req_n;
            interval       <= interval_n;
            interval_valid <= iv_n;
            frame_num      <= fnum_n;
            drop_count     <= drop_n;
            lost           <= lost_n;
        end
    end

endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: self-checking bench for frame_sync with a timestamp
// based reference model, directed scenarios and random stimulus.
module tb_frame_sync;

    localparam int TO   = 1000;
    localparam int DW   = 2;
    localparam int DMAX = 3;
    localparam int P    = 200;

    logic          CLK = 1'b0;
    logic          RST;
    logic          enable;
    logic          frame;
    logic          ack;
    logic          req;
    logic [31:0]   interval;
    logic          interval_valid;
    logic [15:0]   frame_num;
    logic [DW-1:0] drop_count;
    logic          lost;

    int vectors = 0;
    int errors  = 0;

    frame_sync #(
        .TIMEOUT (32'd1000),
        .DROP_W  (DW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .enable         (enable),
        .frame          (frame),
        .ack            (ack),
        .req            (req),
        .interval       (interval),
        .interval_valid (interval_valid),
        .frame_num      (frame_num),
        .drop_count     (drop_count),
        .lost           (lost)
    );

    always #5 CLK = ~CLK;

    // Reference model: tracks the edge index of the last tick instead of
    // a gap counter; interval and watchdog come from timestamp arithmetic.
    longint      cyc    = 0;
    longint      m_last = 0;
    bit          m_on   = 0;
    bit          m_have = 0;
    bit          m_req  = 0;
    bit          m_iv   = 0;
    bit          m_lost = 0;
    logic [31:0] m_int  = '0;
    int          m_fnum = 0;
    int          m_drop = 0;

    always @(posedge CLK) begin
        logic [52:0] act;
        logic [52:0] exp_v;
        cyc++;
        if (RST || !enable) begin
            m_on   = 0;
            m_have = 0;
            m_req  = 0;
            m_iv   = 0;
            m_lost = 0;
            m_int  = '0;
            m_fnum = 0;
            m_drop = 0;
        end else if (!m_on) begin
            m_on   = 1;
            m_have = 0;
            m_iv   = 0;
        end else begin
            m_iv = 0;
            if (frame) begin
                m_fnum = (m_fnum + 1) % 65536;
                if (m_req && !ack && m_drop < DMAX) m_drop++;
                if (m_have && !m_lost) begin
                    m_int = 32'(cyc - m_last);
                    m_iv  = 1;
                end
                m_lost = 0;
                m_last = cyc;
                m_have = 1;
                m_req  = 1;
            end else begin
                if (ack) m_req = 0;
                if (m_have && (cyc - m_last) >= TO) m_lost = 1;
            end
        end
        #1;
        act   = {req, interval_valid, lost, interval,
                 frame_num, drop_count};
        exp_v = {m_req, m_iv, m_lost, m_int,
                 16'(m_fnum), DW'(m_drop)};
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL cycle %0d: got req=%0b iv=%0b lost=%0b int=%0d fn=%0d drop=%0d, want req=%0b iv=%0b lost=%0b int=%0d fn=%0d drop=%0d",
                     cyc, req, interval_valid, lost, interval,
                     frame_num, drop_count, m_req, m_iv, m_lost,
                     m_int, m_fnum, m_drop);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic drive(input logic f, input logic a,
                         input logic e, input logic r);
        @(negedge CLK);
        frame  = f;
        ack    = a;
        enable = e;
        RST    = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        RST    = 1'b1;
        enable = 1'b0;
        frame  = 1'b0;
        ack    = 1'b0;

        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_req", 32'(req), 32'd0);
        chk("reset_fnum", 32'(frame_num), 32'd0);
        chk("reset_lost", 32'(lost), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // steady rate with ack ten cycles after each request
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            chk("steady_fnum", 32'(frame_num), 32'(k));
            chk("steady_req", 32'(req), 32'd1);
            chk("steady_iv", 32'(interval_valid), 32'(k > 1));
            if (k > 1) chk("steady_int", interval, 32'(P));
            idle(8);
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            idle(P - 11);
        end
        chk("steady_drop", 32'(drop_count), 32'd0);
        chk("steady_lost", 32'(lost), 32'd0);

        // tick+ack together, then ticks on consecutive cycles
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b_int", interval, 32'd1);
        chk("b2b_req", 32'(req), 32'd1);
        chk("b2b_drop", 32'(drop_count), 32'd0);
        chk("b2b_fnum", 32'(frame_num), 32'd7);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // slow consumer
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            idle(99);
            drive(1'b1, 1'b0, 1'b1, 1'b0);
        end
        idle(49);
        chk("slow_req_hi", 32'(req), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("slow_req_lo", 32'(req), 32'd0);
        chk("slow_drop", 32'(drop_count), 32'd3);

        // watchdog
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(998);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wd_lost_999", 32'(lost), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wd_lost_1000", 32'(lost), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wd_clear", 32'(lost), 32'd0);
        chk("wd_req", 32'(req), 32'd1);
        chk("wd_no_iv", 32'(interval_valid), 32'd0);
        idle(48);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wd_int50", interval, 32'd50);
        chk("wd_iv50", 32'(interval_valid), 32'd1);

        // re-enable restarts counters, then saturate drops
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("off_fnum", 32'(frame_num), 32'd0);
        chk("off_drop", 32'(drop_count), 32'd0);
        chk("off_int", interval, 32'd0);
        repeat (6) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            idle(2);
        end
        chk("sat_fnum", 32'(frame_num), 32'd6);
        chk("sat_drop", 32'(drop_count), 32'd3);

        // enable drop during REQ, late ack ignored
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("abort_req", 32'(req), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("abort_ack", 32'(req), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stray_req", 32'(req), 32'd0);
        chk("reen_fnum", 32'(frame_num), 32'd0);

        // RST mid-transaction
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_fnum", 32'(frame_num), 32'd2);
        chk("pre_rst_drop", 32'(drop_count), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_fnum", 32'(frame_num), 32'd0);
        chk("rst_int", interval, 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // random phases with varying tick rates
        for (int ph = 0; ph < 20; ph++) begin
            int rate;
            case ($urandom_range(4))
                0: rate = 1;
                1: rate = 3;
                2: rate = 30;
                3: rate = 400;
                default: rate = 3000;
            endcase
            for (int i = 0; i < 1500; i++) begin
                drive($urandom_range(rate - 1) == 0,
                      $urandom_range(3) == 0,
                      $urandom_range(999) != 0,
                      $urandom_range(2999) == 0);
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
